// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types for the host-side UART controller.
//   byte_t      : one UART payload byte
//   tx_state_e  : TX pacing FSM states (one byte in flight at a time)
//   rx_state_e  : RX draining FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_GUARD,
    TX_BUSY
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_CAPTURE
  } rx_state_e;

endpackage

// File: rtl/uart_host_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head output. This is used for both
// the TX and the RX byte buffers.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear; overrides any same-cycle push/pop
//   push, wdata  : write request and data (accepted when not full, or when
//                  a pop frees the slot in the same cycle)
//   pop          : read request (ignored when empty)
//   head         : entry at the read pointer
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// uart_host_ctrl
// Host-side controller for the UART core's parallel load/unload interface.
//
// Handshake rule for the s_tx_* and m_rx_* streams: a byte moves on a rising
// clk edge where valid and ready are both 1. The source holds its data stable
// while valid=1 and ready=0. s_tx_ready depends only on TX FIFO state.
//
// Ports
//   clk, reset_n            : system clock (also the core's txclk/rxclk), async reset
//   s_tx_data/valid/ready   : host -> TX FIFO byte stream
//   m_rx_data/valid/ready   : RX FIFO -> host byte stream
//   tx_en_cfg, rx_en_cfg    : passed straight through to tx_enable / rx_enable
//   flush                   : clears both FIFOs on the next edge
//   clr_status              : clears the sticky rx_stall flag
//   ld_tx_data, tx_data     : load pulse and byte to the core
//   tx_empty                : core TX holding register empty
//   uld_rx_data             : unload pulse to the core
//   rx_data, rx_empty       : core byte (valid the cycle after the unload), core has data
//   tx_count, rx_count      : FIFO occupancies
//   tx_idle                 : nothing queued, nothing in flight, core empty
//   rx_stall                : sticky; core held a byte while the RX FIFO was full
//   tx_state, rx_state      : debug view of the two FSMs
// ---------------------------------------------------------------------------
module uart_host_ctrl
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  byte_t                       s_tx_data,
  input  logic                        s_tx_valid,
  output logic                        s_tx_ready,
  output byte_t                       m_rx_data,
  output logic                        m_rx_valid,
  input  logic                        m_rx_ready,
  input  logic                        tx_en_cfg,
  input  logic                        rx_en_cfg,
  input  logic                        flush,
  input  logic                        clr_status,
  output logic                        ld_tx_data,
  output byte_t                       tx_data,
  input  logic                        tx_empty,
  output logic                        tx_enable,
  output logic                        uld_rx_data,
  input  byte_t                       rx_data,
  input  logic                        rx_empty,
  output logic                        rx_enable,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        tx_idle,
  output logic                        rx_stall,
  output tx_state_e                   tx_state,
  output rx_state_e                   rx_state
);

  byte_t tx_head;
  logic  tx_fifo_full;
  logic  tx_fifo_empty;
  logic  tx_push;
  logic  tx_pop;

  byte_t rx_head;
  logic  rx_fifo_full;
  logic  rx_fifo_empty;
  logic  rx_push;
  logic  rx_pop;
  logic  stall_set;

  assign tx_enable = tx_en_cfg;
  assign rx_enable = rx_en_cfg;

  // ---------------------------------------------------------------- TX side
  assign s_tx_ready = !tx_fifo_full;
  assign tx_push    = s_tx_valid && s_tx_ready;
  // A load is never started in a flush cycle, because the flush empties the FIFO.
  assign tx_pop     = (tx_state == TX_IDLE) && !tx_fifo_empty && tx_empty && !flush;
  assign tx_idle    = tx_fifo_empty && (tx_state == TX_IDLE) && tx_empty;

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (tx_push),
    .wdata   (s_tx_data),
    .pop     (tx_pop),
    .head    (tx_head),
    .full    (tx_fifo_full),
    .empty   (tx_fifo_empty),
    .count   (tx_count)
  );

  // The core clears tx_empty one edge after it sees the load. TX_GUARD skips
  // that stale cycle so TX_BUSY only ever observes the real frame status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      ld_tx_data <= 1'b0;
      tx_data    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          ld_tx_data <= 1'b0;
          if (tx_pop) begin
            tx_data    <= tx_head;
            ld_tx_data <= 1'b1;
            tx_state   <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          ld_tx_data <= 1'b0;
          tx_state   <= TX_BUSY;
        end
        TX_BUSY: begin
          ld_tx_data <= 1'b0;
          if (tx_empty) begin
            tx_state <= TX_IDLE;
          end
        end
        default: begin
          ld_tx_data <= 1'b0;
          tx_state   <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  assign m_rx_valid = !rx_fifo_empty;
  assign m_rx_data  = rx_head;
  assign rx_pop     = m_rx_valid && m_rx_ready;
  // A capture that coincides with flush is dropped rather than pushed.
  assign rx_push    = (rx_state == RX_CAPTURE) && !flush;

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (rx_push),
    .wdata   (rx_data),
    .pop     (rx_pop),
    .head    (rx_head),
    .full    (rx_fifo_full),
    .empty   (rx_fifo_empty),
    .count   (rx_count)
  );

  // The core has a byte, but the FIFO has no room for it.
  assign stall_set = (rx_state == RX_IDLE) && !uld_rx_data && !rx_empty && rx_fifo_full;

  // The unload pulse is issued from RX_IDLE. The FSM stays in RX_IDLE while the
  // pulse is high, then moves to RX_CAPTURE for the cycle in which the core's
  // rx_data is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state    <= RX_IDLE;
      uld_rx_data <= 1'b0;
      rx_stall    <= 1'b0;
    end else begin
      if (stall_set) begin
        rx_stall <= 1'b1;
      end else if (clr_status) begin
        rx_stall <= 1'b0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (uld_rx_data) begin
            uld_rx_data <= 1'b0;
            rx_state    <= RX_CAPTURE;
          end else if (!rx_empty && !rx_fifo_full) begin
            uld_rx_data <= 1'b1;
          end
        end
        RX_CAPTURE: begin
          uld_rx_data <= 1'b0;
          rx_state    <= RX_IDLE;
        end
        default: begin
          uld_rx_data <= 1'b0;
          rx_state    <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_host_ctrl
// Bench for uart_host_ctrl. It contains a behavioural UART core: the TX side
// takes a frame of FRAME cycles per loaded byte, and the RX side presents
// queued bytes with gaps between them. Expected byte streams are kept in
// queues, and pulse rules are checked on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_host_ctrl;
  import uart_pkg::*;

  localparam int FRAME = 10;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ DUT signals
  byte_t       s_tx_data;
  logic        s_tx_valid;
  logic        s_tx_ready;
  byte_t       m_rx_data;
  logic        m_rx_valid;
  logic        m_rx_ready;
  logic        tx_en_cfg;
  logic        rx_en_cfg;
  logic        flush;
  logic        clr_status;
  logic        ld_tx_data;
  byte_t       tx_data;
  logic        tx_empty;
  logic        tx_enable;
  logic        uld_rx_data;
  byte_t       rx_data;
  logic        rx_empty;
  logic        rx_enable;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic        tx_idle;
  logic        rx_stall;
  tx_state_e   tx_state;
  rx_state_e   rx_state;

  uart_host_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tx_data   (s_tx_data),
    .s_tx_valid  (s_tx_valid),
    .s_tx_ready  (s_tx_ready),
    .m_rx_data   (m_rx_data),
    .m_rx_valid  (m_rx_valid),
    .m_rx_ready  (m_rx_ready),
    .tx_en_cfg   (tx_en_cfg),
    .rx_en_cfg   (rx_en_cfg),
    .flush       (flush),
    .clr_status  (clr_status),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_empty    (tx_empty),
    .tx_enable   (tx_enable),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_enable   (rx_enable),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .tx_idle     (tx_idle),
    .rx_stall    (rx_stall),
    .tx_state    (tx_state),
    .rx_state    (rx_state)
  );

  // ------------------------------------------------------------ scoreboard
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ core model
  logic  core_tx_empty;
  logic  tx_block = 1'b0;
  int    frame_cnt;
  assign tx_empty = core_tx_empty && !tx_block;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_tx_empty <= 1'b1;
      frame_cnt     <= 0;
    end else if (ld_tx_data) begin
      core_tx_empty <= 1'b0;
      frame_cnt     <= FRAME;
    end else if (!core_tx_empty) begin
      if (frame_cnt <= 1) core_tx_empty <= 1'b1;
      frame_cnt <= frame_cnt - 1;
    end
  end

  byte_t core_q[$];
  byte_t rx_hold;
  int    rx_gap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_empty <= 1'b1;
      rx_data  <= '0;
      rx_hold  <= '0;
      rx_gap   <= 0;
    end else if (uld_rx_data && !rx_empty) begin
      rx_data  <= rx_hold;
      rx_empty <= 1'b1;
      rx_gap   <= 3;
    end else if (rx_gap > 0) begin
      rx_gap <= rx_gap - 1;
    end else if (rx_empty && core_q.size() > 0) begin
      rx_hold  <= core_q.pop_front();
      rx_empty <= 1'b0;
    end
  end

  // ------------------------------------------------------------ monitor
  int   cyc = 0;
  int   last_ld = -1000;
  int   ld_cnt = 0;
  int   uld_cnt = 0;
  logic prev_ld = 1'b0;
  logic prev_uld = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ld_tx_data) begin
        check("ld_only_when_tx_empty", tx_empty, 1'b1);
        check("ld_one_cycle", prev_ld, 1'b0);
        check("ld_spacing_ge_11", (cyc - last_ld) >= FRAME + 1, 1'b1);
        check("tx_expected_byte_exists", tx_exp_q.size() != 0, 1'b1);
        if (tx_exp_q.size() != 0) check("tx_byte_order", tx_data, tx_exp_q.pop_front());
        ld_cnt++;
        last_ld = cyc;
      end
      if (uld_rx_data) begin
        check("uld_only_when_rx_full", rx_empty, 1'b0);
        check("uld_one_cycle", prev_uld, 1'b0);
        uld_cnt++;
      end
      if (m_rx_valid && m_rx_ready) begin
        check("rx_expected_byte_exists", rx_exp_q.size() != 0, 1'b1);
        if (rx_exp_q.size() != 0) check("rx_byte_order", m_rx_data, rx_exp_q.pop_front());
      end
    end
    prev_ld  = ld_tx_data;
    prev_uld = uld_rx_data;
  end

  // ------------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input byte_t b);
    int guard = 0;
    s_tx_valid = 1'b1;
    s_tx_data  = b;
    while (!s_tx_ready && guard < 500) begin
      tick();
      guard++;
    end
    check("push_ready_timeout", guard < 500, 1'b1);
    tick();
    tx_exp_q.push_back(b);
    s_tx_valid = 1'b0;
  endtask

  task automatic deliver_rx(input byte_t b);
    core_q.push_back(b);
    rx_exp_q.push_back(b);
  endtask

  task automatic wait_tx_drain(input int limit, input string tag);
    int n = 0;
    while (!(tx_idle && tx_count == 0) && n < limit) begin
      tick();
      n++;
    end
    check(tag, n < limit, 1'b1);
  endtask

  // ------------------------------------------------------------ stimulus
  int l0;
  int u0;
  int n;

  initial begin
    s_tx_data  = '0;
    s_tx_valid = 1'b0;
    m_rx_ready = 1'b0;
    tx_en_cfg  = 1'b0;
    rx_en_cfg  = 1'b1;
    flush      = 1'b0;
    clr_status = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tx_ready", s_tx_ready, 1'b1);
    check("rst_m_rx_valid", m_rx_valid, 1'b0);
    check("rst_m_rx_data", m_rx_data, 8'h00);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_stall", rx_stall, 1'b0);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_ld_tx_data", ld_tx_data, 1'b0);
    check("rst_uld_rx_data", uld_rx_data, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("tx_enable_low", tx_enable, 1'b0);
    check("rx_enable_high", rx_enable, 1'b1);
    tx_en_cfg = 1'b1;
    rx_en_cfg = 1'b0;
    #1;
    check("tx_enable_high", tx_enable, 1'b1);
    check("rx_enable_low", rx_enable, 1'b0);
    rx_en_cfg = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // A single byte: the load starts within 2 cycles and is paced by the core
    push_tx(8'hA5);
    n = 0;
    while (!ld_tx_data && n < 5) begin
      tick();
      n++;
    end
    check("ld_latency_le_2", n <= 2, 1'b1);
    check("ld_data_a5", tx_data, 8'hA5);
    tick();
    check("ld_dropped_after_1", ld_tx_data, 1'b0);
    check("tx_idle_low_in_frame", tx_idle, 1'b0);
    wait_tx_drain(100, "tx_idle_timeout_a5");
    check("ld_count_a5", ld_cnt, 1);

    // Three back-to-back bytes
    l0 = ld_cnt;
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    wait_tx_drain(200, "tx_idle_timeout_123");
    check("ld_count_123", ld_cnt - l0, 3);
    check("tx_q_empty_123", tx_exp_q.size(), 0);

    // The FIFO fills while the core is busy
    l0 = ld_cnt;
    tx_block = 1'b1;
    for (int i = 0; i < 8; i++) push_tx(byte_t'($urandom_range(0, 255)));
    check("full_s_tx_ready", s_tx_ready, 1'b0);
    check("full_tx_count", tx_count, 8);
    check("full_no_ld", ld_cnt - l0, 0);
    tx_block = 1'b0;
    repeat (4) tick();
    check("full_ready_back", s_tx_ready, 1'b1);
    check("full_count_7", tx_count, 7);
    wait_tx_drain(400, "tx_idle_timeout_full");
    check("ld_count_full", ld_cnt - l0, 8);

    // A flush drops bytes that are queued but not yet loaded
    l0 = ld_cnt;
    tx_block = 1'b1;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tx_exp_q.delete();
    check("flush_tx_count", tx_count, 0);
    check("flush_s_tx_ready", s_tx_ready, 1'b1);
    tx_block = 1'b0;
    repeat (20) tick();
    check("flush_no_ld", ld_cnt - l0, 0);

    // A single received byte
    deliver_rx(8'h5A);
    n = 0;
    while (!uld_rx_data && n < 20) begin
      tick();
      n++;
    end
    check("uld_timeout_5a", n < 20, 1'b1);
    tick();
    check("uld_pulse_1", uld_rx_data, 1'b0);
    tick();
    check("rx_valid_5a", m_rx_valid, 1'b1);
    check("rx_data_5a", m_rx_data, 8'h5A);
    check("rx_count_5a", rx_count, 1);
    m_rx_ready = 1'b1;
    tick();
    m_rx_ready = 1'b0;
    check("rx_count_after_pop", rx_count, 0);

    // RX overflow: a stall, then recovery
    u0 = uld_cnt;
    for (int i = 0; i < 9; i++) deliver_rx(byte_t'($urandom_range(0, 255)));
    repeat (120) tick();
    check("ovf_rx_count", rx_count, 8);
    check("ovf_rx_stall", rx_stall, 1'b1);
    check("ovf_uld_8", uld_cnt - u0, 8);
    m_rx_ready = 1'b1;
    tick();
    m_rx_ready = 1'b0;
    repeat (15) tick();
    check("ovf_uld_9", uld_cnt - u0, 9);
    check("ovf_rx_count_refill", rx_count, 8);
    check("ovf_stall_sticky", rx_stall, 1'b1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_status_stall", rx_stall, 1'b0);
    m_rx_ready = 1'b1;
    n = 0;
    while (rx_count != 0 && n < 50) begin
      tick();
      n++;
    end
    m_rx_ready = 1'b0;
    check("rx_drain_timeout", n < 50, 1'b1);
    check("rx_q_empty_ovf", rx_exp_q.size(), 0);

    // Reset in the middle of a frame
    push_tx(8'hC1);
    push_tx(8'hC2);
    push_tx(8'hC3);
    push_tx(8'hC4);
    repeat (3) tick();
    check("midrst_busy", tx_state, TX_BUSY);
    check("midrst_count3", tx_count, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_ld", ld_tx_data, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_tx_count", tx_count, 0);
    check("midrst_s_tx_ready", s_tx_ready, 1'b1);
    check("midrst_tx_idle", tx_idle, 1'b1);
    check("midrst_state", tx_state, TX_IDLE);
    check("midrst_m_rx_valid", m_rx_valid, 1'b0);
    tx_exp_q.delete();
    core_q.delete();
    rx_exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    l0 = ld_cnt;
    repeat (30) tick();
    check("midrst_no_ld", ld_cnt - l0, 0);
    push_tx(8'h3C);
    wait_tx_drain(100, "tx_idle_timeout_3c");
    check("midrst_new_ld", ld_cnt - l0, 1);

    // Random traffic on both directions
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 15)) tick();
          push_tx(byte_t'($urandom_range(0, 255)));
        end
      end
      begin
        for (int j = 0; j < 16; j++) begin
          deliver_rx(byte_t'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 20)) tick();
        end
      end
      begin
        for (int k = 0; k < 300; k++) begin
          m_rx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_rx_ready = 1'b1;
    n = 0;
    while (!(tx_idle && tx_count == 0 && rx_count == 0 && core_q.size() == 0 && rx_empty
             && !uld_rx_data && rx_state == RX_IDLE) && n < 2000) begin
      tick();
      n++;
    end
    m_rx_ready = 1'b0;
    check("rand_drain_timeout", n < 2000, 1'b1);
    check("rand_tx_q_empty", tx_exp_q.size(), 0);
    check("rand_rx_q_empty", rx_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- Host-side controller that sits on the parallel side of the team's UART core, the opposite end of its load/unload byte interface.
- Buffers outgoing bytes in a TX FIFO and paces them into the core with ld_tx_data/tx_empty.
- Drains received bytes from the core with uld_rx_data/rx_empty into an RX FIFO.
- Presents valid/ready byte streams to the system. The core's txclk and rxclk are tied to clk.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 8, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; also drives the core's txclk and rxclk.
- reset_n  in  1  asynchronous active-low reset.
- s_tx_data  in  8  byte to transmit.
- s_tx_valid  in  1  host offers s_tx_data.
- s_tx_ready  out  1  TX FIFO not full.
- m_rx_data  out  8  received byte, FIFO head.
- m_rx_valid  out  1  RX FIFO not empty.
- m_rx_ready  in  1  host accepts m_rx_data.
- tx_en_cfg  in  1  drives the core's tx_enable.
- rx_en_cfg  in  1  drives the core's rx_enable.
- flush  in  1  synchronous clear of both FIFOs.
- clr_status  in  1  clears rx_stall.
- ld_tx_data  out  1  load pulse to the core.
- tx_data  out  8  byte to the core.
- tx_empty  in  1  core TX holding register empty.
- tx_enable  out  1  equals tx_en_cfg.
- uld_rx_data  out  1  unload pulse to the core.
- rx_data  in  8  core output byte; valid the cycle after uld_rx_data.
- rx_empty  in  1  core has no unread byte.
- rx_enable  out  1  equals rx_en_cfg.
- tx_count  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- tx_idle  out  1  TX FIFO empty, TX FSM in TX_IDLE, and tx_empty=1.
- rx_stall  out  1  sticky: core held a byte while the RX FIFO was full.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - FIFOs empty; both FSMs idle.
  - ld_tx_data=0, uld_rx_data=0, tx_data=0.
  - s_tx_ready=1, m_rx_valid=0, m_rx_data=0.
  - tx_count=0, rx_count=0, rx_stall=0.
  - tx_idle=1 when tx_empty=1.
- A mid-frame reset abandons the FSM state; the core is reset by the same reset.
- Handshakes: a transfer occurs on a clock edge where valid and ready are both 1.
  - s_tx_ready depends only on FIFO state.
  - m_rx_data must be stable while m_rx_valid=1 and m_rx_ready=0.
- TX FSM, one byte in flight at a time:
  - TX_IDLE: if the FIFO is non-empty and tx_empty=1, then pop the head into tx_data, assert ld_tx_data for exactly 1 cycle, and go to TX_GUARD.
  - TX_GUARD: ignore tx_empty for 1 cycle, because the core clears it one edge after the load. Go to TX_BUSY.
  - TX_BUSY: wait for tx_empty=1, then go to TX_IDLE.
  - Minimum load-to-load spacing is therefore the frame time plus 1 cycle. ld_tx_data is never asserted while tx_empty=0.
  - tx_en_cfg=0 does not change FSM state. The core restarts the byte when re-enabled.
- RX FSM:
  - RX_IDLE: if rx_empty=0 and the RX FIFO is not full, assert uld_rx_data for 1 cycle and go to RX_CAPTURE.
  - RX_CAPTURE: push rx_data into the FIFO, then go to RX_IDLE. rx_empty is already 1 at this point.
  - In RX_IDLE, if rx_empty=0 and the FIFO is full, set rx_stall. No unload occurs until space frees.
  - clr_status clears rx_stall. If clr_status coincides with a new stall condition, set wins.
- FIFO rules:
  - Simultaneous push and pop: count unchanged. This is allowed even when the FIFO is full on the TX side, because the pop frees the slot first.
  - Pointers wrap modulo depth.
  - A push into a full FIFO or a pop from an empty one is impossible by construction.
- flush:
  - Empties both FIFOs next edge and overrides any same-cycle push or pop.
  - Does not cancel a byte already loaded into the core, or an RX_CAPTURE in progress; that captured byte is discarded.

Decomposition:
- Package uart_pkg holds:
  - typedef byte_t (8 bits);
  - enum tx_state_e {TX_IDLE, TX_GUARD, TX_BUSY};
  - enum rx_state_e {RX_IDLE, RX_CAPTURE}.
- Sub-module sync_fifo (parameters DEPTH, WIDTH) is instantiated twice, for TX and RX.

Test Plan:
- Reset with tx_empty=1, then push 0xA5 -> ld_tx_data pulses 1 cycle with tx_data=0xA5 within 2 cycles; tx_idle=0 until the core reasserts tx_empty.
- Push 0x01, 0x02, 0x03 back-to-back, with a core model frame time of 10 cycles -> exactly three ld pulses in order, each only when tx_empty=1, spaced ≥11 cycles apart.
- Fill the TX FIFO with 8 bytes while tx_empty=0 -> s_tx_ready=0 and tx_count=8; the first load completes and ready reasserts.
- Core presents 0x5A (rx_empty=0) -> uld_rx_data for 1 cycle; m_rx_valid=1 with m_rx_data=0x5A 2 cycles later; rx_count=1.
- Hold m_rx_ready=0 and deliver 9 bytes -> rx_count=8, no 9th uld pulse, rx_stall=1; pop one byte -> 9th byte unloaded; clr_status -> rx_stall=0.
- reset_n low while in TX_BUSY with 3 bytes queued -> all outputs return to reset values asynchronously; no ld pulse after release until new data is pushed.
